// File: rtl/lbp_histogram_if.sv
// Stream bundle between the LBP stage, the histogram block and the
// feature stage. Handshake rule for the hist_* port: a bin moves on
// a rising clk edge where hist_valid and hist_ready are both high.
// While hist_valid is high and hist_ready is low, hist_bin, hist_count
// and hist_last stay stable. hist_valid never drops without a transfer
// (reset excepted).
interface lbp_histogram_if #(
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 14
);
   logic              lbp_valid;
   logic [ADDR_W-1:0] lbp_addr;
   logic [7:0]        lbp_data;
   logic              finish;
   logic              hist_valid;
   logic              hist_ready;
   logic [7:0]        hist_bin;
   logic [CNT_W-1:0]  hist_count;
   logic              hist_last;
   logic [ADDR_W:0]   total_count;
   logic              done;
   logic              drop_err;
   logic              busy;
   logic              dbg_state;

   // producer of LBP codes and consumer of bins
   modport master (
      output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
      input  hist_valid, hist_bin, hist_count, hist_last,
             total_count, done, drop_err, busy, dbg_state
   );

   // histogram block
   modport slave (
      input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
      output hist_valid, hist_bin, hist_count, hist_last,
             total_count, done, drop_err, busy, dbg_state
   );
endinterface

// File: rtl/lbp_histogram.sv
// 256-bin histogram of LBP codes over the interior of one frame.
// A finish rising edge dumps all bins over the hist_* stream, then
// the bins clear for the next frame.
module lbp_histogram #(
   parameter int IMG_LOG2 = 7,
   parameter int ADDR_W   = 2 * IMG_LOG2,
   parameter int CNT_W    = 14
) (
   input  logic clk,
   input  logic reset,
   lbp_histogram_if.slave bus
);
   typedef enum logic {ACCUM = 1'b0, DUMP = 1'b1} state_t;

   localparam logic [CNT_W-1:0]    CNT_MAX = '1;
   localparam logic [ADDR_W:0]     TOT_MAX = '1;
   localparam logic [IMG_LOG2-1:0] EDGE_HI = '1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bin_q [256];
   logic [ADDR_W:0]    total_q;
   logic               finish_q;
   logic               hist_valid_q, hist_valid_d;
   logic [7:0]         hist_bin_q, hist_bin_d;
   logic [CNT_W-1:0]   hist_count_q, hist_count_d;
   logic               done_q, done_d;
   logic               drop_err_q;

   logic [IMG_LOG2-1:0] row, col;
   logic                interior, accept, trigger, xfer, last_xfer;
   logic [CNT_W-1:0]    bin0_next;
   logic [7:0]          next_bin;

   assign row       = bus.lbp_addr[ADDR_W-1:IMG_LOG2];
   assign col       = bus.lbp_addr[IMG_LOG2-1:0];
   assign interior  = (row != '0) && (row != EDGE_HI) &&
                      (col != '0) && (col != EDGE_HI);
   assign accept    = (state_q == ACCUM) && bus.lbp_valid && interior;
   assign trigger   = (state_q == ACCUM) && bus.finish && !finish_q;
   assign xfer      = (state_q == DUMP) && hist_valid_q && bus.hist_ready;
   assign last_xfer = xfer && (hist_bin_q == 8'd255);
   assign next_bin  = hist_bin_q + 8'd1;

   // bin 0 as it will stand after this edge, so a sample arriving with
   // the trigger shows up in the first beat
   assign bin0_next = (accept && bus.lbp_data == 8'd0 && bin_q[0] != CNT_MAX) ?
                      bin_q[0] + 1'b1 : bin_q[0];

   // bin and total counters: saturating increment in ACCUM, clear after last beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) bin_q[i] <= '0;
         total_q <= '0;
      end else if (last_xfer) begin
         for (int i = 0; i < 256; i++) bin_q[i] <= '0;
         total_q <= '0;
      end else if (accept) begin
         if (bin_q[bus.lbp_data] != CNT_MAX)
            bin_q[bus.lbp_data] <= bin_q[bus.lbp_data] + 1'b1;
         if (total_q != TOT_MAX)
            total_q <= total_q + 1'b1;
      end
   end

   // state and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ACCUM;
         hist_valid_q <= 1'b0;
         hist_bin_q   <= '0;
         hist_count_q <= '0;
         done_q       <= 1'b0;
         finish_q     <= 1'b0;
         drop_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hist_valid_q <= hist_valid_d;
         hist_bin_q   <= hist_bin_d;
         hist_count_q <= hist_count_d;
         done_q       <= done_d;
         finish_q     <= bus.finish;
         if (state_q == DUMP && bus.lbp_valid) drop_err_q <= 1'b1;
      end
   end

   // next-state and next-output decode
   always_comb begin
      state_d      = state_q;
      hist_valid_d = hist_valid_q;
      hist_bin_d   = hist_bin_q;
      hist_count_d = hist_count_q;
      done_d       = 1'b0;
      case (state_q)
         ACCUM: begin
            if (trigger) begin
               state_d      = DUMP;
               hist_valid_d = 1'b1;
               hist_bin_d   = 8'd0;
               hist_count_d = bin0_next;
            end
         end
         DUMP: begin
            if (last_xfer) begin
               state_d      = ACCUM;
               hist_valid_d = 1'b0;
               hist_bin_d   = 8'd0;
               hist_count_d = '0;
               done_d       = 1'b1;
            end else if (xfer) begin
               hist_bin_d   = next_bin;
               hist_count_d = bin_q[next_bin];
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   assign bus.hist_valid  = hist_valid_q;
   assign bus.hist_bin    = hist_bin_q;
   assign bus.hist_count  = hist_count_q;
   assign bus.hist_last   = (hist_bin_q == 8'd255);
   assign bus.total_count = total_q;
   assign bus.done        = done_q;
   assign bus.drop_err    = drop_err_q;
   assign bus.busy        = (state_q == DUMP);
   assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_lbp_histogram.sv
// Directed bench for lbp_histogram. Two instances share one stimulus
// stream: the full-width one and a CNT_W=4 one that shows saturation.
module tb_lbp_histogram;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   logic [31:0] exp_q[$];

   lbp_histogram_if #(.ADDR_W(14), .CNT_W(14)) mif ();
   lbp_histogram_if #(.ADDR_W(14), .CNT_W(4))  sif ();

   assign sif.lbp_valid  = mif.lbp_valid;
   assign sif.lbp_addr   = mif.lbp_addr;
   assign sif.lbp_data   = mif.lbp_data;
   assign sif.finish     = mif.finish;
   assign sif.hist_ready = mif.hist_ready;

   lbp_histogram #(.IMG_LOG2(7), .ADDR_W(14), .CNT_W(14)) dut (
      .clk(clk), .reset(reset), .bus(mif.slave));
   lbp_histogram #(.IMG_LOG2(7), .ADDR_W(14), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .bus(sif.slave));

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] pix(input int r, input int c);
      logic [6:0] rr;
      logic [6:0] cc;
      rr = 7'(r);
      cc = 7'(c);
      return {rr, cc};
   endfunction

   task automatic put(input logic [13:0] a, input logic [7:0] d);
      @(negedge clk);
      mif.lbp_valid = 1'b1;
      mif.lbp_addr  = a;
      mif.lbp_data  = d;
   endtask

   task automatic idle();
      @(negedge clk);
      mif.lbp_valid = 1'b0;
   endtask

   task automatic pulse_finish();
      @(negedge clk);
      mif.lbp_valid = 1'b0;
      mif.finish    = 1'b1;
      @(negedge clk);
      mif.finish    = 1'b0;
   endtask

   task automatic exp_clear();
      exp_q.delete();
      for (int i = 0; i < 256; i++) exp_q.push_back(32'd0);
   endtask

   // collect a full dump; rnd adds random ready, a 5-cycle stall at bin 10
   // and a stray lbp_valid at beat 20
   task automatic run_dump(input bit rnd);
      int beats;
      int cycles;
      int stall;
      bit injected;
      logic [31:0] e;
      beats = 0; cycles = 0; stall = 0; injected = 0;
      while (beats < 256 && cycles < 4000) begin
         @(negedge clk);
         cycles++;
         mif.lbp_valid = 1'b0;
         if (rnd && !injected && beats == 20) begin
            mif.lbp_valid = 1'b1;
            mif.lbp_addr  = pix(40, 40);
            mif.lbp_data  = 8'd200;
            injected = 1;
         end
         if (rnd && mif.hist_valid && mif.hist_bin == 8'd10 && stall < 5) begin
            mif.hist_ready = 1'b0;
            chk("stall_bin", 32'(mif.hist_bin), 32'd10);
            chk("stall_cnt", 32'(mif.hist_count), exp_q[0]);
            stall++;
         end else begin
            mif.hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (mif.hist_valid && mif.hist_ready) begin
            e = exp_q.pop_front();
            chk("beat_bin", 32'(mif.hist_bin), 32'(beats));
            chk("beat_cnt", 32'(mif.hist_count), e);
            chk("beat_last", 32'(mif.hist_last), 32'(beats == 255));
            chk("sat_cnt", 32'(sif.hist_count), (e > 32'd15) ? 32'd15 : e);
            beats++;
         end
      end
      chk("dump_beats", 32'(beats), 32'd256);
      if (rnd) chk("stall_len", 32'(stall), 32'd5);
      @(negedge clk);
      mif.hist_ready = 1'b0;
      mif.lbp_valid  = 1'b0;
      chk("end_valid", 32'(mif.hist_valid), 32'd0);
      chk("end_done", 32'(mif.done), 32'd1);
      chk("end_busy", 32'(mif.busy), 32'd0);
      chk("end_total", 32'(mif.total_count), 32'd0);
      chk("end_done_s", 32'(sif.done), 32'd1);
      @(negedge clk);
      chk("done_pulse", 32'(mif.done), 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      mif.lbp_valid  = 1'b0;
      mif.lbp_addr   = '0;
      mif.lbp_data   = '0;
      mif.finish     = 1'b0;
      mif.hist_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(mif.hist_valid), 32'd0);
      chk("rst_busy", 32'(mif.busy), 32'd0);
      chk("rst_total", 32'(mif.total_count), 32'd0);
      chk("rst_done", 32'(mif.done), 32'd0);
      chk("rst_drop", 32'(mif.drop_err), 32'd0);
      chk("rst_bin", 32'(mif.hist_bin), 32'd0);
      chk("rst_cnt", 32'(mif.hist_count), 32'd0);
      chk("rst_last", 32'(mif.hist_last), 32'd0);
      reset = 1'b0;

      // full interior, all code 0
      for (int r = 1; r <= 126; r++)
         for (int c = 1; c <= 126; c++)
            put(pix(r, c), 8'd0);
      idle();
      chk("f1_total", 32'(mif.total_count), 32'd15876);
      pulse_finish();
      chk("f1_valid", 32'(mif.hist_valid), 32'd1);
      chk("f1_busy", 32'(mif.busy), 32'd1);
      exp_clear();
      exp_q[0] = 32'd15876;
      run_dump(1'b0);

      // border addresses ignored
      put(14'd0, 8'h11);
      put(14'd127, 8'h11);
      put(14'd128, 8'h11);
      put(14'd16383, 8'h11);
      put(pix(5, 9), 8'h5A);
      idle();
      chk("f2_total", 32'(mif.total_count), 32'd1);
      pulse_finish();
      exp_clear();
      exp_q[8'h5A] = 32'd1;
      run_dump(1'b0);

      // back-to-back strobes plus a sample in the trigger cycle
      put(pix(10, 10), 8'd3);
      put(pix(10, 11), 8'd3);
      put(pix(10, 12), 8'd3);
      put(pix(10, 13), 8'd7);
      put(pix(10, 14), 8'd3);
      idle();
      @(negedge clk);
      mif.lbp_valid = 1'b1;
      mif.lbp_addr  = pix(20, 20);
      mif.lbp_data  = 8'd7;
      mif.finish    = 1'b1;
      @(negedge clk);
      mif.lbp_valid = 1'b0;
      mif.finish    = 1'b0;
      chk("f3_total", 32'(mif.total_count), 32'd6);
      chk("f3_first", 32'(mif.hist_count), 32'd0);
      chk("f3_drop0", 32'(mif.drop_err), 32'd0);
      exp_clear();
      exp_q[3] = 32'd4;
      exp_q[7] = 32'd2;
      run_dump(1'b1);
      chk("f3_drop1", 32'(mif.drop_err), 32'd1);

      // finish held across the dump and beyond: one dump only
      put(pix(50, 60), 8'd9);
      put(pix(51, 60), 8'd9);
      @(negedge clk);
      mif.lbp_valid = 1'b0;
      mif.finish    = 1'b1;
      exp_clear();
      exp_q[9] = 32'd2;
      run_dump(1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_busy", 32'(mif.busy), 32'd0);
      end
      mif.finish = 1'b0;
      chk("hold_drop", 32'(mif.drop_err), 32'd1);

      // saturation on the narrow instance
      for (int i = 0; i < 20; i++) put(pix(30, 1 + i), 8'd1);
      idle();
      chk("f5_total_s", 32'(sif.total_count), 32'd20);
      pulse_finish();
      exp_clear();
      exp_q[1] = 32'd20;
      run_dump(1'b0);

      // reset in the middle of a dump
      put(pix(3, 3), 8'd4);
      put(pix(3, 4), 8'd4);
      idle();
      pulse_finish();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mif.hist_ready = 1'b1;
      end
      @(negedge clk);
      mif.hist_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_valid", 32'(mif.hist_valid), 32'd0);
      chk("mid_busy", 32'(mif.busy), 32'd0);
      chk("mid_total", 32'(mif.total_count), 32'd0);
      chk("mid_drop", 32'(mif.drop_err), 32'd0);
      chk("mid_bin", 32'(mif.hist_bin), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      pulse_finish();
      exp_clear();
      run_dump(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
